// File: rtl/non_max_suppression.sv
// Streaming Canny non-maximum suppression over a 3x3 window built from two line buffers.
// Output is registered one edge after the window-completing pixel is accepted; no backpressure.
module non_max_suppression #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int MAG_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MAG_W-1:0] mag_in,
  input  logic [1:0]       dir_in,
  input  logic             in_valid,
  output logic [MAG_W-1:0] nms_mag_out,
  output logic             nms_out_valid,
  output logic             frame_done
);

  localparam int PW = MAG_W + 2;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Each entry packs {dir, mag}.
  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic [PW-1:0] lb2 [IMG_WIDTH];

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  // win[row][col]: row 0 = r-2, row 2 = current row; col 2 = newest column.
  logic [PW-1:0] win [3][3];
  logic          win_vld;
  logic          win_last;

  logic [MAG_W-1:0] c_mag;
  logic [1:0]       c_dir;
  logic [MAG_W-1:0] n1_mag;
  logic [MAG_W-1:0] n2_mag;
  logic             keep;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2[col_cnt] <= lb1[col_cnt];
      lb1[col_cnt] <= {dir_in, mag_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt       <= '0;
      row_cnt       <= '0;
      win_vld       <= 1'b0;
      win_last      <= 1'b0;
      nms_mag_out   <= '0;
      nms_out_valid <= 1'b0;
      frame_done    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      win_vld  <= in_valid && (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);
      win_last <= in_valid && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb2[col_cnt];
        win[1][2] <= lb1[col_cnt];
        win[2][2] <= {dir_in, mag_in};

        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end

      nms_out_valid <= win_vld;
      frame_done    <= win_vld && win_last;
      if (win_vld) begin
        nms_mag_out <= keep ? c_mag : '0;
      end
    end
  end

  always_comb begin
    c_mag  = win[1][1][MAG_W-1:0];
    c_dir  = win[1][1][PW-1:MAG_W];
    n1_mag = win[1][0][MAG_W-1:0];
    n2_mag = win[1][2][MAG_W-1:0];
    case (c_dir)
      2'd1: begin
        n1_mag = win[0][2][MAG_W-1:0];
        n2_mag = win[2][0][MAG_W-1:0];
      end
      2'd2: begin
        n1_mag = win[0][1][MAG_W-1:0];
        n2_mag = win[2][1][MAG_W-1:0];
      end
      2'd3: begin
        n1_mag = win[0][0][MAG_W-1:0];
        n2_mag = win[2][2][MAG_W-1:0];
      end
      default: begin
        n1_mag = win[1][0][MAG_W-1:0];
        n2_mag = win[1][2][MAG_W-1:0];
      end
    endcase
    keep = (c_mag >= n1_mag) && (c_mag >= n2_mag);
  end

endmodule

// File: tb/tb_non_max_suppression.sv
// Directed scoreboard bench for non_max_suppression on a 5x5 frame.
module tb_non_max_suppression;

  localparam int W = 5;
  localparam int H = 5;
  localparam int MW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] mag_in = '0;
  logic [1:0]    dir_in = '0;
  logic          in_valid = 1'b1;
  logic [MW-1:0] nms_mag_out;
  logic          nms_out_valid;
  logic          frame_done;

  non_max_suppression #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(MW)) dut (
    .clk           (clk),
    .rst           (rst),
    .mag_in        (mag_in),
    .dir_in        (dir_in),
    .in_valid      (in_valid),
    .nms_mag_out   (nms_mag_out),
    .nms_out_valid (nms_out_valid),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mag;
    int last;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   img_m [H][W];
  int   img_d [H][W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference decision taken straight from the image, independent of any window.
  function automatic int model(input int r, input int c);
    int m, n1, n2;
    m = img_m[r][c];
    case (img_d[r][c])
      1:       begin n1 = img_m[r-1][c+1]; n2 = img_m[r+1][c-1]; end
      2:       begin n1 = img_m[r-1][c];   n2 = img_m[r+1][c];   end
      3:       begin n1 = img_m[r-1][c-1]; n2 = img_m[r+1][c+1]; end
      default: begin n1 = img_m[r][c-1];   n2 = img_m[r][c+1];   end
    endcase
    return (m >= n1 && m >= n2) ? m : 0;
  endfunction

  task automatic set_img(input int kind, input int d);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        img_d[r][c] = d;
        case (kind)
          0:       img_m[r][c] = 100;
          1:       img_m[r][c] = (c == 2) ? 200 : 50;
          default: img_m[r][c] = (r == c) ? 300 : 10;
        endcase
      end
    end
  endtask

  task automatic push_pix(input int r, input int c, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      mag_in   = MW'($urandom);
      dir_in   = 2'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    mag_in   = MW'(img_m[r][c]);
    dir_in   = 2'(img_d[r][c]);
    if (r >= 2 && c >= 2) begin
      sb.push_back('{model(r-1, c-1), (r == H-1 && c == W-1) ? 1 : 0, cyc + 2});
    end
  endtask

  task automatic drive_frame(input int gap_max);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        push_pix(r, c, (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
      end
    end
  endtask

  task automatic settle(input string tag, input int start_out, input int exp_cnt);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_pending"}, sb.size(), 0);
    check({tag, "_count"}, n_out - start_out, exp_cnt);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (nms_out_valid) begin
      n_out++;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_output observed=%0d expected=no output", nms_mag_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_mag", 32'(nms_mag_out), e.mag);
        check("out_frame_done", 32'(frame_done), e.last);
        check("out_latency_cycle", cyc, e.cyc);
      end
    end else begin
      check("idle_frame_done", 32'(frame_done), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    // Reset held with in_valid high.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_valid", 32'(nms_out_valid), 0);
      check("rst_mag", 32'(nms_mag_out), 0);
      check("rst_frame_done", 32'(frame_done), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // Uniform frame followed back-to-back by the column-ridge frame.
    base = n_out;
    set_img(0, 0);
    drive_frame(0);
    set_img(1, 0);
    drive_frame(0);
    settle("uniform_ridge", base, 18);

    base = n_out;
    set_img(2, 3);
    drive_frame(0);
    settle("diag_dir3", base, 9);

    base = n_out;
    set_img(2, 1);
    drive_frame(0);
    settle("diag_dir1", base, 9);

    base = n_out;
    drive_frame(3);
    settle("diag_dir1_gaps", base, 9);

    // Abort a frame at pixel (3,1), then run a fresh one.
    base = n_out;
    set_img(2, 3);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!(r == 3 && c >= 1)) push_pix(r, c, 0);
      end
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    mag_in   = MW'(img_m[3][1]);
    dir_in   = 2'(img_d[3][1]);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pending", sb.size(), 0);
    check("abort_count", n_out - base, 3);
    base = n_out;
    set_img(0, 2);
    img_m[2][2] = 40;
    img_m[1][3] = 500;
    drive_frame(1);
    settle("after_reset", base, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
